// File: rtl/viterbi_decoder_hd.sv
// Hard-decision rate-1/2 Viterbi decoder: full-parallel ACS over all 2^(K-1) states,
// register-exchange survivors, one decoded bit D symbols after its symbol arrives.
module viterbi_decoder_hd #(
    parameter int           K      = 5,
    parameter logic [7:0]   G0_OCT = 8'o35,
    parameter logic [7:0]   G1_OCT = 8'o23,
    parameter int           D      = 32,
    parameter int           W      = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           seed_load,
    input  logic [K-2:0]   seed_value,
    input  logic           in_valid,
    input  logic [1:0]     in_sym,
    output logic           out_valid,
    output logic           out_bit
);

    localparam int M  = K - 1;
    localparam int S  = 1 << M;
    localparam int CW = $clog2(D + 1);

    localparam logic [K-1:0] G0_MASK = G0_OCT[K-1:0];
    localparam logic [K-1:0] G1_MASK = G1_OCT[K-1:0];
    localparam logic [W-1:0] PM_MAX  = {W{1'b1}};
    localparam logic [W-1:0] PM_INIT = W'(4 * K);

    logic [W-1:0]   r_pm   [S];
    logic [D-2:0]   r_surv [S];
    logic [CW-1:0]  r_cnt;
    logic           r_out_valid;
    logic           r_out_bit;

    logic [W-1:0]   w_pm_new   [S];
    logic [W-1:0]   w_pm_norm  [S];
    logic [D-1:0]   w_surv_new [S];
    logic [W-1:0]   w_min;
    logic [M-1:0]   w_best;
    logic           w_lt;
    logic           w_eligible;
    logic           w_cand;
    logic [CW-1:0]  w_cnt_next;

    function automatic logic [1:0] exp_sym(input logic [K-1:0] r);
        return {^(r & G0_MASK), ^(r & G1_MASK)};
    endfunction

    function automatic logic [1:0] hamming(input logic [1:0] a, input logic [1:0] b);
        logic [1:0] x;
        x = a ^ b;
        return {1'b0, x[1]} + {1'b0, x[0]};
    endfunction

    function automatic logic [W-1:0] sat_add(input logic [W-1:0] pm, input logic [1:0] bm);
        logic [W:0] s;
        s = {1'b0, pm} + {{(W-1){1'b0}}, bm};
        return s[W] ? PM_MAX : s[W-1:0];
    endfunction

    // Per-state add-compare-select; predecessor p0 wins ties.
    for (genvar n = 0; n < S; n++) begin : g_acs
        localparam logic [M-1:0] NS = M'(n);
        localparam logic [M-1:0] P0 = {NS[M-2:0], 1'b0};
        localparam logic [M-1:0] P1 = {NS[M-2:0], 1'b1};

        logic [W-1:0] w_c0;
        logic [W-1:0] w_c1;
        logic         w_sel1;

        assign w_c0   = sat_add(r_pm[P0], hamming(in_sym, exp_sym({NS[M-1], P0})));
        assign w_c1   = sat_add(r_pm[P1], hamming(in_sym, exp_sym({NS[M-1], P1})));
        assign w_sel1 = (w_c1 < w_c0);

        assign w_pm_new[n]   = w_sel1 ? w_c1 : w_c0;
        assign w_surv_new[n] = w_sel1 ? {r_surv[P1], NS[M-1]} : {r_surv[P0], NS[M-1]};
        assign w_pm_norm[n]  = w_pm_new[n] - w_min;
    end

    // Minimum metric and lowest-index state holding it.
    always_comb begin
        w_min  = w_pm_new[0];
        w_best = '0;
        w_lt   = 1'b0;
        for (int n = 1; n < S; n++) begin
            w_lt   = (w_pm_new[n] < w_min);
            w_best = w_lt ? M'(n) : w_best;
            w_min  = w_lt ? w_pm_new[n] : w_min;
        end
    end

    // Output candidate, eligibility and saturating fill count.
    always_comb begin
        w_cand     = w_surv_new[w_best][D-1];
        w_eligible = (r_cnt >= CW'(D - 1));
        w_cnt_next = (r_cnt == CW'(D)) ? r_cnt : r_cnt + CW'(1);
    end

    // Trellis state, survivors, fill counter and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int n = 0; n < S; n++) begin
                r_pm[n]   <= (n == 0) ? {W{1'b0}} : PM_INIT;
                r_surv[n] <= '0;
            end
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_out_bit   <= 1'b0;
        end else if (seed_load) begin
            for (int n = 0; n < S; n++) begin
                r_pm[n]   <= (M'(n) == seed_value) ? {W{1'b0}} : PM_INIT;
                r_surv[n] <= '0;
            end
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
        end else if (in_valid) begin
            for (int n = 0; n < S; n++) begin
                r_pm[n]   <= w_pm_norm[n];
                r_surv[n] <= w_surv_new[n][D-2:0];
            end
            r_cnt       <= w_cnt_next;
            r_out_valid <= w_eligible;
            if (w_eligible) begin
                r_out_bit <= w_cand;
            end else begin
                r_out_bit <= r_out_bit;
            end
        end else begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_bit   = r_out_bit;

endmodule
